// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state encoding and glitch-counter ceiling for button_debouncer
package debounce_pkg;
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;
  localparam logic [7:0] GLITCH_MAX = 8'd255;
endpackage

// File: rtl/d_flipflop.sv
// d_flipflop: single D register with synchronous active-high reset (clock, reset, data_in -> data_out)
module d_flipflop (
  input  logic clock,
  input  logic reset,
  input  logic data_in,
  output logic data_out
);
  always_ff @(posedge clock)
    data_out <= reset ? 1'b0 : data_in;
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchroniser + stability FSM; ports clock, reset, data_in -> level, pulse_rise, pulse_fall, glitch_cnt[7:0]
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  localparam int CNT_W = $clog2(STABLE_CYCLES)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in,
  output logic       level,
  output logic       pulse_rise,
  output logic       pulse_fall,
  output logic [7:0] glitch_cnt
);
  logic s1, raw;
  db_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic level_n, rise_n, fall_n;
  logic [7:0] glitch_n, glitch_inc;
  d_flipflop u_sync1 (.clock(clock), .reset(reset), .data_in(data_in), .data_out(s1));
  d_flipflop u_sync2 (.clock(clock), .reset(reset), .data_in(s1), .data_out(raw));
  assign glitch_inc = (glitch_cnt == GLITCH_MAX) ? glitch_cnt : glitch_cnt + 8'd1;
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    level_n  = level;
    rise_n   = 1'b0;
    fall_n   = 1'b0;
    glitch_n = glitch_cnt;
    unique case (state)
      IDLE_LOW: if (raw) begin
        state_n = WAIT_HIGH;
        cnt_n   = CNT_W'(1);
      end
      WAIT_HIGH: if (!raw) begin
        state_n  = IDLE_LOW;
        cnt_n    = '0;
        glitch_n = glitch_inc;
      end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
        state_n = IDLE_HIGH;
        cnt_n   = '0;
        level_n = 1'b1;
        rise_n  = 1'b1;
      end else cnt_n = cnt + CNT_W'(1);
      IDLE_HIGH: if (!raw) begin
        state_n = WAIT_LOW;
        cnt_n   = CNT_W'(1);
      end
      WAIT_LOW: if (raw) begin
        state_n  = IDLE_HIGH;
        cnt_n    = '0;
        glitch_n = glitch_inc;
      end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
        state_n = IDLE_LOW;
        cnt_n   = '0;
        level_n = 1'b0;
        fall_n  = 1'b1;
      end else cnt_n = cnt + CNT_W'(1);
      default: state_n = IDLE_LOW;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state      <= IDLE_LOW;
      cnt        <= '0;
      level      <= 1'b0;
      pulse_rise <= 1'b0;
      pulse_fall <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      level      <= level_n;
      pulse_rise <= rise_n;
      pulse_fall <= fall_n;
      glitch_cnt <= glitch_n;
    end
endmodule
